// File: rtl/single_cycle_pkg.sv
// Shared decode constants, ALU/immediate/write-back enums and the immediate generator
// for the single_cycle RV32I subset core.
package single_cycle_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_SW   = 3'd2;
    localparam logic [2:0] F3_JALR = 3'd0;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef enum logic [1:0] {WB_ALU, WB_IMM, WB_MEM, WB_PC4} wb_sel_e;

    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            default:    return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/single_cycle_alu.sv
// Combinational 32-bit ALU; zero/less flags feed the branch comparator.
module single_cycle_alu
    import single_cycle_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero,
    output logic        less
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign less = $signed(a) < $signed(b);

endmodule

// File: rtl/single_cycle.sv
// Single-cycle RV32I subset core with internal ROM, register file and data RAM.
// Define SINGLE_CYCLE_TRACE_EN to print one line per retired instruction.
module single_cycle
  import single_cycle_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter string       IMEM_FILE  = "program.hex"
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned IA = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DA = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] regs [32];

  logic [31:0] PC;
  logic [31:0] instruction;

  assign instruction = imem[PC[IA+1:2]];

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign f3     = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign f7     = instruction[31:25];

  alu_op_e  alu_op;
  imm_fmt_e imm_fmt;
  wb_sel_e  wb_sel;
  logic     use_imm, alu_a_pc, reg_we, mem_we, is_branch, is_jal, is_jalr;

  always_comb begin
    alu_op    = ALU_ADD;
    imm_fmt   = IMM_I;
    wb_sel    = WB_ALU;
    use_imm   = 1'b0;
    alu_a_pc  = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_R: begin
        alu_op = alu_decode(f3, f7[5]);
        if (f7 == F7_BASE ||
            (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)))
          reg_we = 1'b1;
      end
      OP_I: begin
        // bit 30 only selects sra for shifts; for addi it is immediate data
        alu_op  = alu_decode(f3, (f3 == F3_SRL_SRA) && f7[5]);
        use_imm = 1'b1;
        case (f3)
          F3_SLL:     reg_we = (f7 == F7_BASE);
          F3_SRL_SRA: reg_we = (f7 == F7_BASE) || (f7 == F7_ALT);
          default:    reg_we = 1'b1;
        endcase
      end
      OP_LOAD: begin
        use_imm = 1'b1;
        wb_sel  = WB_MEM;
        reg_we  = (f3 == F3_LW);
      end
      OP_STORE: begin
        use_imm = 1'b1;
        imm_fmt = IMM_S;
        mem_we  = (f3 == F3_SW);
      end
      OP_BRANCH: begin
        alu_op    = ALU_SUB;
        imm_fmt   = IMM_B;
        is_branch = (f3 == F3_BEQ) || (f3 == F3_BNE) ||
                    (f3 == F3_BLT) || (f3 == F3_BGE);
      end
      OP_LUI: begin
        imm_fmt = IMM_U;
        wb_sel  = WB_IMM;
        reg_we  = 1'b1;
      end
      OP_AUIPC: begin
        imm_fmt  = IMM_U;
        use_imm  = 1'b1;
        alu_a_pc = 1'b1;
        reg_we   = 1'b1;
      end
      OP_JAL: begin
        imm_fmt = IMM_J;
        wb_sel  = WB_PC4;
        reg_we  = 1'b1;
        is_jal  = 1'b1;
      end
      OP_JALR: begin
        use_imm = 1'b1;
        wb_sel  = WB_PC4;
        reg_we  = (f3 == F3_JALR);
        is_jalr = (f3 == F3_JALR);
      end
      default: ;
    endcase
  end

  logic [31:0] imm, rs1_val, rs2_val, alu_a, alu_b, alu_result;
  logic [31:0] mem_rdata, wb_data, pc_plus4, pc_target, pc_next;
  logic        alu_zero, alu_less, taken;

  assign imm     = imm_gen(instruction, imm_fmt);
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign alu_a   = alu_a_pc ? PC : rs1_val;
  assign alu_b   = use_imm ? imm : rs2_val;

  single_cycle_alu alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .less   (alu_less)
  );

  assign mem_rdata = dmem[alu_result[DA+1:2]];
  assign pc_plus4  = PC + 32'd4;
  assign pc_target = PC + imm;

  always_comb begin
    taken = 1'b0;
    case (f3)
      F3_BEQ:  taken = alu_zero;
      F3_BNE:  taken = !alu_zero;
      F3_BLT:  taken = alu_less;
      F3_BGE:  taken = !alu_less;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    wb_data = alu_result;
    case (wb_sel)
      WB_IMM:  wb_data = imm;
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_result;
    endcase
  end

  always_comb begin
    pc_next = pc_plus4;
    if (is_jal || (is_branch && taken))
      pc_next = pc_target;
    else if (is_jalr)
      pc_next = alu_result & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) PC <= '0;
    else       PC <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_we && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) dmem[alu_result[DA+1:2]] <= rs2_val;
  end

`ifdef SINGLE_CYCLE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (reg_we && rd != 5'd0)
        $display("%0t pc=%08h instr=%08h x%0d=%08h", $time, PC, instruction, rd, wb_data);
      else
        $display("%0t pc=%08h instr=%08h", $time, PC, instruction);
    end
  end
`endif

endmodule

// File: tb/tb_single_cycle.sv
// Self-checking bench for single_cycle: loads a program into the ROM, tracks the PC
// through a scoreboard queue and checks architectural state against a vector table.
module tb_single_cycle;

    localparam int OPC_I    = 7'b0010011;
    localparam int OPC_LOAD = 7'b0000011;
    localparam int OPC_JALR = 7'b1100111;
    localparam int OPC_LUI  = 7'b0110111;
    localparam int OPC_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int unsigned tests = 0;
    int unsigned failed = 0;

    logic [31:0] rom_img [256];
    logic [31:0] exp_regs [32];
    logic [31:0] sb_pc [$];

    typedef struct {
        int unsigned idx;
        logic [31:0] value;
    } reg_vec_t;
    reg_vec_t vecs [$];

    always #5 clk = ~clk;

    single_cycle #(
        .IMEM_DEPTH (256),
        .DMEM_DEPTH (256),
        .IMEM_FILE  ("")
    ) dut (
        .clk   (clk),
        .reset (reset)
    );

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int unsigned cycles;

        for (int i = 0; i < 256; i++) rom_img[i] = '0;
        rom_img[8'h00 >> 2] = enc_i(5, 0, 0, 1, OPC_I);          // addi x1,x0,5
        rom_img[8'h04 >> 2] = enc_i(-3, 0, 0, 2, OPC_I);         // addi x2,x0,-3
        rom_img[8'h08 >> 2] = enc_r(0, 2, 1, 0, 3);              // add  x3,x1,x2
        rom_img[8'h0C >> 2] = enc_r(32, 2, 1, 0, 4);             // sub  x4,x1,x2
        rom_img[8'h10 >> 2] = enc_b(8, 0, 0, 0);                 // beq  x0,x0,+8
        rom_img[8'h14 >> 2] = enc_i(1, 0, 0, 6, OPC_I);          // addi x6,x0,1 (skipped)
        rom_img[8'h18 >> 2] = enc_i(1, 9, 0, 9, OPC_I);          // addi x9,x9,1
        rom_img[8'h1C >> 2] = enc_b(12, 3, 9, 5);                // bge  x9,x3,+12
        rom_img[8'h20 >> 2] = enc_j(-16, 1);                     // jal  x1,-16
        rom_img[8'h24 >> 2] = enc_j(8, 0);                       // jal  x0,+8
        rom_img[8'h28 >> 2] = enc_i(0, 1, 0, 0, OPC_JALR);       // jalr x0,0(x1)
        rom_img[8'h2C >> 2] = enc_r(0, 1, 2, 2, 5);              // slt  x5,x2,x1
        rom_img[8'h30 >> 2] = enc_i(7, 0, 0, 0, OPC_I);          // addi x0,x0,7
        rom_img[8'h34 >> 2] = enc_i(32'h55, 0, 0, 7, OPC_I);     // addi x7,x0,0x55
        rom_img[8'h38 >> 2] = enc_s(8, 7, 0, 2);                 // sw   x7,8(x0)
        rom_img[8'h3C >> 2] = enc_i(8, 0, 2, 8, OPC_LOAD);       // lw   x8,8(x0)
        rom_img[8'h40 >> 2] = 32'hFFFF_FFFF;                     // undecodable
        rom_img[8'h44 >> 2] = enc_r(0, 7, 1, 4, 22);             // xor  x22,x1,x7
        rom_img[8'h48 >> 2] = enc_i(32'h401, 2, 5, 14, OPC_I);   // srai x14,x2,1
        rom_img[8'h4C >> 2] = enc_i(28, 2, 5, 15, OPC_I);        // srli x15,x2,28
        rom_img[8'h50 >> 2] = enc_u(32'h12345, 16, OPC_LUI);     // lui  x16,0x12345
        rom_img[8'h54 >> 2] = enc_u(1, 17, OPC_AUIPC);           // auipc x17,1
        rom_img[8'h58 >> 2] = enc_i(-1, 16, 4, 18, OPC_I);       // xori x18,x16,-1
        rom_img[8'h5C >> 2] = enc_i(32'h25, 1, 3, 19, OPC_I);    // sltiu x19,x1,0x25
        rom_img[8'h60 >> 2] = enc_r(0, 7, 1, 6, 20);             // or   x20,x1,x7
        rom_img[8'h64 >> 2] = enc_r(0, 9, 7, 1, 21);             // sll  x21,x7,x9
        rom_img[8'h68 >> 2] = enc_j(0, 0);                       // jal  x0,0 (park)
        for (int i = 0; i < 256; i++) dut.imem[i] = rom_img[i];

        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        exp_regs[1]  = 32'h0000_0024;
        exp_regs[2]  = 32'hFFFF_FFFD;
        exp_regs[3]  = 32'h0000_0002;
        exp_regs[4]  = 32'h0000_0008;
        exp_regs[5]  = 32'h0000_0001;
        exp_regs[7]  = 32'h0000_0055;
        exp_regs[8]  = 32'h0000_0055;
        exp_regs[9]  = 32'h0000_0002;
        exp_regs[14] = 32'hFFFF_FFFE;
        exp_regs[15] = 32'h0000_000F;
        exp_regs[16] = 32'h1234_5000;
        exp_regs[17] = 32'h0000_1054;
        exp_regs[18] = 32'hEDCB_AFFF;
        exp_regs[19] = 32'h0000_0001;
        exp_regs[20] = 32'h0000_0075;
        exp_regs[21] = 32'h0000_0154;
        exp_regs[22] = 32'h0000_0071;
        for (int i = 0; i < 32; i++) begin
            reg_vec_t v;
            v.idx = i;
            v.value = exp_regs[i];
            vecs.push_back(v);
        end

        reset = 1'b1;
        tick();
        tick();
        check("reset_pc", dut.PC, 32'h0);
        check("reset_instr", dut.instruction, rom_img[0]);
        for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), dut.regs[i], 32'h0);

        foreach (rom_img[k]) begin
            if (k == 0) begin
                sb_pc.push_back(32'h00); sb_pc.push_back(32'h04); sb_pc.push_back(32'h08);
                sb_pc.push_back(32'h0C); sb_pc.push_back(32'h10); sb_pc.push_back(32'h18);
                sb_pc.push_back(32'h1C); sb_pc.push_back(32'h20); sb_pc.push_back(32'h10);
                sb_pc.push_back(32'h18); sb_pc.push_back(32'h1C); sb_pc.push_back(32'h28);
                sb_pc.push_back(32'h24); sb_pc.push_back(32'h2C);
                for (int a = 32'h30; a <= 32'h68; a += 4) sb_pc.push_back(a);
                sb_pc.push_back(32'h68); sb_pc.push_back(32'h68);
            end
        end

        reset = 1'b0;
        while (sb_pc.size() > 0) begin
            exp_pc = sb_pc.pop_front();
            check($sformatf("pc_trace@%02h", exp_pc), dut.PC, exp_pc);
            check($sformatf("instr@%02h", exp_pc), dut.instruction, rom_img[exp_pc[9:2]]);
            tick();
        end

        for (int i = 0; i < vecs.size(); i++)
            check($sformatf("reg_x%0d", vecs[i].idx), dut.regs[vecs[i].idx], vecs[i].value);
        check("dmem_word2", dut.dmem[2], 32'h55);

        // Second run: reset asserted mid-program while PC=0x30
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rerun_pc0", dut.PC, 32'h0);
        cycles = 0;
        while (dut.PC != 32'h30 && cycles < 100) begin
            tick();
            cycles++;
        end
        check("rerun_reach_30", dut.PC, 32'h30);
        check("rerun_x3_before_reset", dut.regs[3], 32'h2);
        check("rerun_x1_before_reset", dut.regs[1], 32'h24);
        reset = 1'b1;
        tick();
        check("midreset_pc", dut.PC, 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("midreset_x%0d", i), dut.regs[i], 32'h0);
        check("midreset_dmem_kept", dut.dmem[2], 32'h55);
        reset = 1'b0;
        tick();
        check("post_reset_pc", dut.PC, 32'h4);
        check("post_reset_x1", dut.regs[1], 32'h5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
